// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader for the 16-bit CPU core.
// Accepts a byte stream (16-bit big-endian word count, then big-endian
// instruction words) over a valid/ready handshake. Each complete word is
// written to instruction memory at ascending addresses. The core is held in
// pc_reset until the whole program has been written.
module instr_loader #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [15:0]       instruction_in,
    output logic              load_instruction,
    output logic [ADDR_W-1:0] load_addr,
    output logic              pc_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       loaded_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_INS_HI = 3'd3,
        S_INS_LO = 3'd4,
        S_WRITE  = 3'd5,
        S_RUN    = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // The idle counter must be able to hold TIMEOUT-1.
    localparam int                TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [15:0]       DEPTH16  = 16'(DEPTH);

    // Registered state and outputs.
    state_t             state_q,            state_d;
    logic [15:0]        count_q,            count_d;
    logic [7:0]         word_hi_q,          word_hi_d;
    logic [ADDR_W-1:0]  index_q,            index_d;
    logic [TMO_W-1:0]   tmo_q,              tmo_d;
    logic [15:0]        instr_q,            instr_d;
    logic               load_instruction_q, load_instruction_d;
    logic [ADDR_W-1:0]  load_addr_q,        load_addr_d;
    logic [15:0]        loaded_count_q,     loaded_count_d;
    logic               byte_ready_q,       byte_ready_d;
    logic               pc_reset_q,         pc_reset_d;
    logic               load_done_q,        load_done_d;
    logic               load_err_q,         load_err_d;

    // Helper terms shared by several states.
    logic               xfer;
    logic [15:0]        cnt_full;
    logic [15:0]        idx_inc;
    logic               tmo_expired;
    logic [TMO_W-1:0]   tmo_inc;

    // byte_ready_q mirrors the state register, so the handshake never
    // depends combinationally on byte_valid.
    assign xfer        = byte_valid && byte_ready_q;
    assign cnt_full    = {count_q[15:8], byte_in};
    assign idx_inc     = 16'(index_q) + 16'd1;
    assign tmo_expired = (tmo_q >= TMO_LAST);
    assign tmo_inc     = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};

    // Next-state, datapath and output decode for the load sequence.
    always_comb begin
        state_d            = state_q;
        count_d            = count_q;
        word_hi_d          = word_hi_q;
        index_d            = index_q;
        tmo_d              = tmo_q;
        instr_d            = instr_q;
        load_addr_d        = load_addr_q;
        loaded_count_d     = loaded_count_q;
        load_instruction_d = 1'b0;

        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_d        = S_CNT_HI;
                    index_d        = '0;
                    loaded_count_d = '0;
                    tmo_d          = '0;
                end
            end
            S_CNT_HI: begin
                // No timeout before the first byte of a transfer.
                tmo_d = '0;
                if (xfer) begin
                    count_d[15:8] = byte_in;
                    state_d       = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    count_d = cnt_full;
                    tmo_d   = '0;
                    if (cnt_full == 16'd0) begin
                        state_d = S_RUN;
                    end else if (cnt_full > DEPTH16) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_INS_HI;
                    end
                end else if (tmo_expired) begin
                    state_d = S_ERR;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_INS_HI: begin
                if (xfer) begin
                    word_hi_d = byte_in;
                    tmo_d     = '0;
                    state_d   = S_INS_LO;
                end else if (tmo_expired) begin
                    state_d = S_ERR;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_INS_LO: begin
                if (xfer) begin
                    // Stage the write so the strobe is a clean register
                    // output during the WRITE cycle.
                    instr_d            = {word_hi_q, byte_in};
                    load_addr_d        = index_q;
                    load_instruction_d = 1'b1;
                    tmo_d              = '0;
                    state_d            = S_WRITE;
                end else if (tmo_expired) begin
                    state_d = S_ERR;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_WRITE: begin
                loaded_count_d = idx_inc;
                tmo_d          = '0;
                if (idx_inc == count_q) begin
                    state_d = S_RUN;
                end else begin
                    index_d = idx_inc[ADDR_W-1:0];
                    state_d = S_INS_HI;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state and registered,
        // so they line up exactly with the state register.
        byte_ready_d = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
                       (state_d == S_INS_HI) || (state_d == S_INS_LO);
        pc_reset_d   = (state_d != S_RUN);
        load_done_d  = (state_d == S_RUN);
        load_err_d   = (state_d == S_ERR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q            <= S_IDLE;
            count_q            <= '0;
            word_hi_q          <= '0;
            index_q            <= '0;
            tmo_q              <= '0;
            instr_q            <= '0;
            load_instruction_q <= 1'b0;
            load_addr_q        <= '0;
            loaded_count_q     <= '0;
            byte_ready_q       <= 1'b0;
            pc_reset_q         <= 1'b1;
            load_done_q        <= 1'b0;
            load_err_q         <= 1'b0;
        end else begin
            state_q            <= state_d;
            count_q            <= count_d;
            word_hi_q          <= word_hi_d;
            index_q            <= index_d;
            tmo_q              <= tmo_d;
            instr_q            <= instr_d;
            load_instruction_q <= load_instruction_d;
            load_addr_q        <= load_addr_d;
            loaded_count_q     <= loaded_count_d;
            byte_ready_q       <= byte_ready_d;
            pc_reset_q         <= pc_reset_d;
            load_done_q        <= load_done_d;
            load_err_q         <= load_err_d;
        end
    end

    assign byte_ready       = byte_ready_q;
    assign instruction_in   = instr_q;
    assign load_instruction = load_instruction_q;
    assign load_addr        = load_addr_q;
    assign pc_reset         = pc_reset_q;
    assign load_done        = load_done_q;
    assign load_err         = load_err_q;
    assign loaded_count     = loaded_count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: directed scenarios plus randomized programs
// checked against a byte-stream reference model.
module tb_instr_loader;

    localparam int DEPTH   = 256;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 1000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [15:0]       instruction_in;
    logic              load_instruction;
    logic [ADDR_W-1:0] load_addr;
    logic              pc_reset;
    logic              load_done;
    logic              load_err;
    logic [15:0]       loaded_count;

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .byte_in          (byte_in),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .instruction_in   (instruction_in),
        .load_instruction (load_instruction),
        .load_addr        (load_addr),
        .pc_reset         (pc_reset),
        .load_done        (load_done),
        .load_err         (load_err),
        .loaded_count     (loaded_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t        got_q[$];
    logic [7:0] prog[$];

    // Record every write strobe seen by the instruction memory.
    always @(negedge clk) begin
        if (load_instruction === 1'b1) begin
            got_q.push_back({load_addr, instruction_in});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns on the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Wait (bounded) until the loader reaches RUN or ERR.
    task automatic wait_settle();
        int n;
        n = 0;
        while (!(load_done === 1'b1 || load_err === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("settle_wait", {30'd0, load_done, load_err}, 32'd2);
    endtask

    // Compare DUT state and recorded writes against the model of 'prog'.
    task automatic check_result(input string tag);
        int  cnt;
        int  exp_n;
        bit  exp_err;
        cnt     = {prog[0], prog[1]};
        exp_err = (cnt > DEPTH);
        exp_n   = exp_err ? 0 : cnt;
        chk({tag, ".load_done"},    {31'd0, load_done},  {31'd0, !exp_err});
        chk({tag, ".load_err"},     {31'd0, load_err},   {31'd0, exp_err});
        chk({tag, ".pc_reset"},     {31'd0, pc_reset},   {31'd0, exp_err});
        chk({tag, ".byte_ready"},   {31'd0, byte_ready}, 32'd0);
        chk({tag, ".loaded_count"}, {16'd0, loaded_count}, exp_n);
        chk({tag, ".n_writes"},     got_q.size(), exp_n);
        for (int i = 0; i < exp_n && i < got_q.size(); i++) begin
            chk($sformatf("%s.addr[%0d]", tag, i), {24'd0, got_q[i].addr}, i);
            chk($sformatf("%s.data[%0d]", tag, i), {16'd0, got_q[i].data},
                {16'd0, prog[2 + 2*i], prog[3 + 2*i]});
        end
        $display("load %s: count=%0d writes=%0d done=%0b err=%0b", tag, cnt, got_q.size(), load_done, load_err);
    endtask

    task automatic run_load(input string tag, input int maxgap);
        got_q.delete();
        do_start();
        foreach (prog[i]) send_byte(prog[i], $urandom_range(0, maxgap));
        wait_settle();
        @(negedge clk);
        check_result(tag);
    endtask

    initial begin
        int r;
        int len;
        int cnt;

        reset_n    = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;

        // 1. Reset state
        repeat (2) @(negedge clk);
        chk("rst.byte_ready",   {31'd0, byte_ready},       32'd0);
        chk("rst.load_instr",   {31'd0, load_instruction}, 32'd0);
        chk("rst.pc_reset",     {31'd0, pc_reset},         32'd1);
        chk("rst.load_done",    {31'd0, load_done},        32'd0);
        chk("rst.load_err",     {31'd0, load_err},         32'd0);
        chk("rst.loaded_count", {16'd0, loaded_count},     32'd0);
        chk("rst.instr_in",     {16'd0, instruction_in},   32'd0);
        chk("rst.load_addr",    {24'd0, load_addr},        32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 2. Two-word program with valid held high, latency checked per word
        got_q.delete();
        prog = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        chk("t2.strobe0",  {31'd0, load_instruction}, 32'd1);
        chk("t2.data0",    {16'd0, instruction_in},   32'h1234);
        chk("t2.addr0",    {24'd0, load_addr},        32'd0);
        chk("t2.pcrst_wr", {31'd0, pc_reset},         32'd1);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        chk("t2.strobe1",  {31'd0, load_instruction}, 32'd1);
        chk("t2.data1",    {16'd0, instruction_in},   32'hABCD);
        chk("t2.addr1",    {24'd0, load_addr},        32'd1);
        @(negedge clk);
        chk("t2.strobe_off", {31'd0, load_instruction}, 32'd0);
        check_result("t2");

        // 3. Count above DEPTH
        prog = '{8'h01, 8'h01};
        run_load("t3", 0);

        // 4. Timeout while waiting for the low byte of a word, then recovery
        got_q.delete();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("t4.err_early", {31'd0, load_err}, 32'd0);
        @(negedge clk);
        chk("t4.err",        {31'd0, load_err},   32'd1);
        chk("t4.pc_reset",   {31'd0, pc_reset},   32'd1);
        chk("t4.byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("t4.n_writes",   got_q.size(),        32'd0);
        prog = '{8'h00, 8'h01, 8'h55, 8'hAA};
        run_load("t4b", 0);

        // 5. Empty program
        prog = '{8'h00, 8'h00};
        run_load("t5", 0);

        // 6. Reset in the middle of the second word
        got_q.delete();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t6.pc_reset",     {31'd0, pc_reset},     32'd1);
        chk("t6.load_done",    {31'd0, load_done},    32'd0);
        chk("t6.byte_ready",   {31'd0, byte_ready},   32'd0);
        chk("t6.loaded_count", {16'd0, loaded_count}, 32'd0);
        repeat (4) @(negedge clk);
        chk("t6.n_writes",     got_q.size(),          32'd1);
        prog = '{8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0F, 8'hF0};
        run_load("t6b", 2);

        // Full-depth program at maximum rate
        prog.delete();
        prog.push_back(8'h01);
        prog.push_back(8'h00);
        for (int i = 0; i < 2 * DEPTH; i++) prog.push_back(8'($urandom));
        run_load("full", 0);

        // Randomized programs with random inter-byte gaps
        for (int it = 0; it < 20; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      cnt = 0;
            else if (r == 1) cnt = $urandom_range(DEPTH + 1, 16'hFFFF);
            else             cnt = $urandom_range(1, 12);
            len = (cnt > DEPTH) ? 0 : cnt;
            prog.delete();
            prog.push_back(8'(cnt >> 8));
            prog.push_back(8'(cnt));
            for (int i = 0; i < 2 * len; i++) prog.push_back(8'($urandom));
            run_load($sformatf("rnd%0d", it), 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
